// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a FIFO.
//
// Words written through a valid/ready handshake are buffered, then sent
// LSB first as start bit, DATA_BITS data bits, an optional parity bit and
// STOP_BITS stop bits. Each bit lasts CLK_DIV clock cycles. When the FIFO
// still holds words, frames follow each other with no idle gap.
//
// Parameters:
//   DATA_BITS  data bits per frame (5..9)
//   CLK_DIV    clk cycles per bit period (>= 2)
//   FIFO_DEPTH transmit buffer entries (power of two, >= 2)
//   PARITY     0 none, 1 even, 2 odd
//   STOP_BITS  1 or 2
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high
//   s_data     word to transmit
//   s_valid    s_data is valid
//   s_ready    FIFO can accept a word
//   tx         serial line, idle high, registered
//   busy       frame in progress or FIFO not empty
//   fifo_count words currently buffered
module uart_tx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int CLK_DIV    = 5208,
   parameter int FIFO_DEPTH = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [DATA_BITS-1:0]                 s_data,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   output logic                                 tx,
   output logic                                 busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
   localparam int STOP_LEN = STOP_BITS * CLK_DIV;
   // The baud counter also times the whole stop period, so size it for that.
   localparam int BAUD_W   = $clog2(STOP_LEN);
   localparam int BIT_W    = $clog2(DATA_BITS);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] START    = 3'd1;
   localparam logic [2:0] DATA     = 3'd2;
   localparam logic [2:0] PAR_BIT  = 3'd3;
   localparam logic [2:0] STOP     = 3'd4;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     count;
   logic [2:0]           state;
   logic [BAUD_W-1:0]    baud;
   logic [BIT_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 par_bit;
   logic [DATA_BITS-1:0] head;
   logic                 push;
   logic                 pop;
   logic                 bit_done;
   logic                 stop_done;

   function automatic logic calc_parity(input logic [DATA_BITS-1:0] word);
      logic p;
      p = ^word;
      return (PARITY == 2) ? ~p : p;
   endfunction

   assign head       = mem[rd_ptr];
   assign s_ready    = (count < CNT_W'(FIFO_DEPTH));
   assign push       = s_valid & s_ready;
   assign bit_done   = (baud == BAUD_W'(CLK_DIV - 1));
   assign stop_done  = (baud == BAUD_W'(STOP_LEN - 1));
   // The FSM takes the head word either from idle or straight out of the
   // last stop cycle, which is what makes back-to-back frames gapless.
   assign pop        = (count != '0) && ((state == IDLE) || ((state == STOP) && stop_done));
   assign busy       = (state != IDLE) || (count != '0);
   assign fifo_count = count;

   // FIFO storage (data only, not cleared by reset)
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem[wr_ptr] <= s_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Transmit FSM: the baud counter restarts on every state entry
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         tx      <= 1'b1;
         baud    <= '0;
         bit_idx <= '0;
      end else begin
         if (pop) begin
            shift   <= head;
            par_bit <= calc_parity(head);
         end
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  state <= START;
                  tx    <= 1'b0;
                  baud  <= '0;
               end
            end
            START: begin
               if (bit_done) begin
                  state   <= DATA;
                  baud    <= '0;
                  bit_idx <= '0;
                  tx      <= shift[0];
                  shift   <= shift >> 1;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            DATA: begin
               if (bit_done) begin
                  baud <= '0;
                  if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                     if (PARITY != 0) begin
                        state <= PAR_BIT;
                        tx    <= par_bit;
                     end else begin
                        state <= STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     tx      <= shift[0];
                     shift   <= shift >> 1;
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            PAR_BIT: begin
               if (bit_done) begin
                  state <= STOP;
                  tx    <= 1'b1;
                  baud  <= '0;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            STOP: begin
               if (stop_done) begin
                  baud <= '0;
                  if (pop) begin
                     state <= START;
                     tx    <= 1'b0;
                  end else begin
                     state <= IDLE;
                     tx    <= 1'b1;
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               baud  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: bench for uart_tx_fifo.
//
// Three instances share clock, reset and the write stream, all with
// CLK_DIV=4, DATA_BITS=8, FIFO_DEPTH=4:
//   d0: no parity, 1 stop bit
//   d1: even parity, 2 stop bits
//   d2: odd parity, 1 stop bit
// A frame-timeline model predicts tx, busy, s_ready and fifo_count of each
// instance every cycle; table vectors and short sequences cover the
// specific frame shapes and corner cases.
module tb_uart_tx_fifo;

   localparam int DIV   = 4;
   localparam int DEPTH = 4;

   logic                 clk;
   logic                 rst;
   logic                 vld;
   logic [7:0]           dat;
   logic [2:0]           tx_w;
   logic [2:0]           busy_w;
   logic [2:0]           rdy_w;
   logic [2:0][2:0]      cnt_w;

   uart_tx_fifo #(.DATA_BITS(8), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .PARITY(0), .STOP_BITS(1)) dut_a (
      .clk(clk), .reset(rst), .s_data(dat), .s_valid(vld), .s_ready(rdy_w[0]),
      .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0]));
   uart_tx_fifo #(.DATA_BITS(8), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .PARITY(1), .STOP_BITS(2)) dut_b (
      .clk(clk), .reset(rst), .s_data(dat), .s_valid(vld), .s_ready(rdy_w[1]),
      .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1]));
   uart_tx_fifo #(.DATA_BITS(8), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .PARITY(2), .STOP_BITS(1)) dut_c (
      .clk(clk), .reset(rst), .s_data(dat), .s_valid(vld), .s_ready(rdy_w[2]),
      .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt_w[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;

   // reference model state, one slot per instance
   int         m_cnt  [3];
   int         m_hd   [3];
   int         m_pos  [3];
   int         m_flen [3];
   bit         m_act  [3];
   logic [7:0] m_q    [3][16];
   logic [15:0] m_fr  [3];

   // traces recorded from a chosen cycle onwards
   logic tr_tx   [3][64];
   logic tr_busy [3][64];
   int   tidx = 64;

   // serial decoder on instance d0
   logic       prev_tx;
   bit         dec_on = 0;
   int         dec_t  = 0;
   logic [7:0] dec_w;
   int         nrx = 0;
   logic [7:0] rx     [8];
   int         starts [8];

   typedef struct {
      logic [7:0]  data;
      logic [9:0]  fa;   // d0 frame, bit 0 sent first
      logic [11:0] fb;   // d1 frame
      logic [10:0] fc;   // d2 frame
   } vec_t;
   vec_t vecs [5];

   function automatic int par_of(input int d);
      return (d == 0) ? 0 : ((d == 1) ? 1 : 2);
   endfunction

   function automatic int stop_of(input int d);
      return (d == 1) ? 2 : 1;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chkn(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Frame-level model: a frame is a list of line levels, each held DIV
   // cycles; the next queued word starts the moment the last one ends.
   task automatic model_step(input int d);
      bit         push;
      bit         pop;
      logic [7:0] w;
      int         nb;
      if (rst) begin
         m_cnt[d] = 0; m_hd[d] = 0; m_act[d] = 0; m_pos[d] = 0;
      end else begin
         push = vld && (m_cnt[d] < DEPTH);
         pop  = 0;
         if (m_act[d]) begin
            if (m_pos[d] == m_flen[d] - 1) begin
               m_act[d] = 0;
               pop = (m_cnt[d] > 0);
            end else begin
               m_pos[d]++;
            end
         end else begin
            pop = (m_cnt[d] > 0);
         end
         if (pop) begin
            w = m_q[d][m_hd[d]];
            m_hd[d] = (m_hd[d] + 1) % 16;
            m_cnt[d]--;
            m_fr[d] = '1;
            m_fr[d][0] = 1'b0;
            m_fr[d][8:1] = w;
            nb = 9;
            if (par_of(d) != 0) begin
               m_fr[d][9] = (($countones(w) % 2) == 1) ^ (par_of(d) == 2);
               nb = 10;
            end
            m_flen[d] = DIV * (nb + stop_of(d));
            m_act[d] = 1;
            m_pos[d] = 0;
         end
         if (push) begin
            m_q[d][(m_hd[d] + m_cnt[d]) % 16] = dat;
            m_cnt[d]++;
         end
      end
   endtask

   task automatic tick();
      logic etx;
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 3; d++) begin
         model_step(d);
         etx = m_act[d] ? m_fr[d][m_pos[d] / DIV] : 1'b1;
         chk1($sformatf("tx_d%0d_c%0d", d, cyc), tx_w[d], etx);
         chk1($sformatf("busy_d%0d_c%0d", d, cyc), busy_w[d], m_act[d] || (m_cnt[d] > 0));
         chk1($sformatf("ready_d%0d_c%0d", d, cyc), rdy_w[d], m_cnt[d] < DEPTH);
         chkn($sformatf("count_d%0d_c%0d", d, cyc), int'(cnt_w[d]), m_cnt[d]);
         if (tidx < 64) begin
            tr_tx[d][tidx]   = tx_w[d];
            tr_busy[d][tidx] = busy_w[d];
         end
      end
      if (tidx < 64) tidx++;
      if (rst) begin
         dec_on = 0;
      end else if (!dec_on) begin
         if (prev_tx === 1'b1 && tx_w[0] === 1'b0) begin
            dec_on = 1;
            dec_t  = 0;
            if (nrx < 8) starts[nrx] = cyc;
         end
      end else begin
         dec_t++;
         if (dec_t >= 6 && dec_t <= 34 && (dec_t % DIV) == 2) dec_w[(dec_t - 6) / DIV] = tx_w[0];
         if (dec_t == 39) begin
            dec_on = 0;
            if (nrx < 8) rx[nrx] = dec_w;
            nrx++;
         end
      end
      prev_tx = tx_w[0];
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_w != 3'b000 && n < 400) begin
         tick();
         n++;
      end
      chk1("wait_idle", busy_w == 3'b000, 1'b1);
      tick();
   endtask

   initial begin
      logic [15:0] expf;
      logic        act;
      logic        e;
      int          nb;
      int          flen;
      int          acc;
      int          c0;
      bit          fell;
      logic [7:0]  words [6];

      vecs[0] = '{8'hA5, 10'b1_10100101_0, 12'b11_0_10100101_0, 11'b1_1_10100101_0};
      vecs[1] = '{8'h07, 10'b1_00000111_0, 12'b11_1_00000111_0, 11'b1_0_00000111_0};
      vecs[2] = '{8'h00, 10'b1_00000000_0, 12'b11_0_00000000_0, 11'b1_1_00000000_0};
      vecs[3] = '{8'hFF, 10'b1_11111111_0, 12'b11_0_11111111_0, 11'b1_1_11111111_0};
      vecs[4] = '{8'h80, 10'b1_10000000_0, 12'b11_1_10000000_0, 11'b1_0_10000000_0};
      words   = '{8'h11, 8'h22, 8'hC3, 8'h5A, 8'h96, 8'hEE};

      // reset state, and a write during reset is dropped
      rst = 1'b1; vld = 1'b0; dat = 8'h00;
      repeat (3) tick();
      chkn("reset_tx", int'(tx_w), 7);
      chkn("reset_busy", int'(busy_w), 0);
      chkn("reset_ready", int'(rdy_w), 7);
      chkn("reset_count", int'(cnt_w[0]), 0);
      vld = 1'b1; dat = 8'h55;
      tick();
      rst = 1'b0; vld = 1'b0;
      tick();
      chkn("rst_drop_count", int'(cnt_w[0]), 0);
      chk1("rst_drop_tx", tx_w[0], 1'b1);
      tick();

      // table vectors: one word, full frame shape on every instance
      for (int i = 0; i < 5; i++) begin
         wait_idle();
         vld = 1'b1; dat = vecs[i].data;
         tick();
         vld = 1'b0;
         tidx = 0;
         repeat (60) tick();
         for (int d = 0; d < 3; d++) begin
            expf = (d == 0) ? 16'(vecs[i].fa) : ((d == 1) ? 16'(vecs[i].fb) : 16'(vecs[i].fc));
            nb   = (d == 0) ? 10 : ((d == 1) ? 12 : 11);
            flen = nb * DIV;
            for (int b = 0; b < nb; b++) begin
               e   = expf[b];
               act = e;
               for (int s = 0; s < DIV; s++) begin
                  if (tr_tx[d][b * DIV + s] !== e) act = tr_tx[d][b * DIV + s];
               end
               chk1($sformatf("vec%0d_d%0d_bit%0d", i, d, b), act, e);
            end
            chk1($sformatf("vec%0d_d%0d_busy_last", i, d), tr_busy[d][flen - 1], 1'b1);
            chk1($sformatf("vec%0d_d%0d_busy_after", i, d), tr_busy[d][flen], 1'b0);
         end
      end

      // six words back-to-back into a depth-4 FIFO
      wait_idle();
      nrx = 0; acc = 0; c0 = 0;
      for (int k = 0; k < 6; k++) begin
         vld = 1'b1; dat = words[k];
         if (rdy_w[0]) acc++;
         tick();
         if (k == 0) c0 = cyc;
         if (k == 1) chkn("burst_count_after_pop", int'(cnt_w[0]), 1);
         if (k == 4) begin
            chk1("burst_ready_full", rdy_w[0], 1'b0);
            chkn("burst_count_full", int'(cnt_w[0]), 4);
         end
      end
      vld = 1'b0;
      chkn("burst_accepted", acc, 5);
      wait_idle();
      chkn("burst_frames", nrx, 5);
      chkn("burst_first_start", starts[0], c0 + 1);
      for (int k = 0; k < 5 && k < nrx; k++) begin
         chkn($sformatf("burst_word%0d", k), int'(rx[k]), int'(words[k]));
         if (k > 0) chkn($sformatf("burst_gap%0d", k), starts[k] - starts[k - 1], 40);
      end

      // write on the same edge as the idle pop
      wait_idle();
      nrx = 0;
      vld = 1'b1; dat = 8'h3C;
      tick();
      dat = 8'hC5;
      tick();
      vld = 1'b0;
      chkn("samedge_count", int'(cnt_w[0]), 1);
      wait_idle();
      chkn("samedge_frames", nrx, 2);
      if (nrx >= 2) begin
         chkn("samedge_word0", int'(rx[0]), 8'h3C);
         chkn("samedge_word1", int'(rx[1]), 8'hC5);
         chkn("samedge_gap", starts[1] - starts[0], 40);
      end

      // two stop bits on d1: 8-cycle stop, next start right after
      wait_idle();
      vld = 1'b1; dat = 8'h00;
      tick();
      dat = 8'hFF;
      tidx = 0;
      tick();
      vld = 1'b0;
      repeat (58) tick();
      act = 1'b1;
      for (int t = 40; t < 48; t++) if (tr_tx[1][t] !== 1'b1) act = tr_tx[1][t];
      chk1("stop2_high", act, 1'b1);
      chk1("stop2_next_start", tr_tx[1][48], 1'b0);

      // reset during data bit 3 with two words queued
      wait_idle();
      nrx = 0;
      vld = 1'b1; dat = 8'h81;
      tick();
      dat = 8'h42;
      tick();
      dat = 8'h24;
      tick();
      vld = 1'b0;
      chkn("midrst_queued", int'(cnt_w[0]), 2);
      repeat (15) tick();
      chk1("midrst_bit3_low", tx_w[0], 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk1("midrst_tx", tx_w[0], 1'b1);
      chkn("midrst_count", int'(cnt_w[0]), 0);
      chk1("midrst_busy", busy_w[0], 1'b0);
      fell = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (tx_w[0] !== 1'b1) fell = 1;
      end
      chk1("midrst_no_frame", fell, 1'b0);
      chk1("midrst_still_idle", busy_w[0], 1'b0);

      // randomized traffic with occasional resets
      for (int blk = 0; blk < 8; blk++) begin
         int rate;
         rate = $urandom_range(5, 100);
         for (int k = 0; k < 500; k++) begin
            vld = ($urandom_range(0, 99) < rate);
            dat = 8'($urandom);
            rst = ($urandom_range(0, 799) == 0);
            tick();
         end
      end
      rst = 1'b0; vld = 1'b0;
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
